clc_key: RTL

Shared-key stage of the Diffie-Hellman datapath. It takes the peer's public value `r2`, the local secret exponent `x` and the prime modulus `p`, and computes `key = r2^x mod p` sequentially: left-to-right square-and-multiply built on a bit-serial interleaved (Blakley) modular multiplier. It sits directly downstream of the public-value stage (`g^x mod p`) and consumes the value the peer produced with that same stage.

---
 rtl/clc_key.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/clc_key.sv
// Shared-key stage: key = r2^x mod p via square-and-multiply over a bit-serial Blakley multiplier.
// Optional build macro CLC_KEY_SKIP_LEAD_EN adds a SCAN state that skips leading zero exponent bits.
module clc_key #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st,
  input  logic [W-1:0] r2,
  input  logic [W-1:0] x,
  input  logic [W-1:0] p,
  output logic [W-1:0] key,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int IW = $clog2(W);

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    SCAN,
    SQR,
    MUL,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]  r2_q, r2_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  p_q, p_d;
  logic [W-1:0]  base_q, base_d;
  logic [W-1:0]  res_q, res_d;
  logic [W+1:0]  acc_q, acc_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  key_q, key_d;
  logic          err_q, err_d;

  logic [W+1:0]  p_ext;
  logic [W+1:0]  red_shift, red_next;
  logic [W+1:0]  dbl, dbl_red, add_v, mul_next;
  logic          mul_bit;
  logic [IW-1:0] i_dec;

  // One reduction step and one Blakley multiply step; the operand register res_q
  // stays fixed for the whole multiply and is only overwritten on its last cycle.
  always_comb begin
    p_ext     = {2'b00, p_q};
    i_dec     = i_q - IW'(1);
    red_shift = (acc_q << 1) | (W+2)'(r2_q[cnt_q]);
    red_next  = (red_shift >= p_ext) ? red_shift - p_ext : red_shift;
    mul_bit   = (state_q == MUL) ? base_q[cnt_q] : res_q[cnt_q];
    dbl       = acc_q << 1;
    dbl_red   = (dbl >= p_ext) ? dbl - p_ext : dbl;
    add_v     = dbl_red + (mul_bit ? {2'b00, res_q} : '0);
    mul_next  = (add_v >= p_ext) ? add_v - p_ext : add_v;
  end

  always_comb begin
    state_d = state_q;
    r2_d    = r2_q;
    x_d     = x_q;
    p_d     = p_q;
    base_d  = base_q;
    res_d   = res_q;
    acc_d   = acc_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (st) begin
          r2_d    = r2;
          x_d     = x;
          p_d     = p;
          res_d   = W'(1);
          base_d  = '0;
          acc_d   = '0;
          i_d     = IW'(W - 1);
          cnt_d   = IW'(W - 1);
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        // A degenerate modulus spends exactly one cycle here before reporting.
        if (p_q < W'(2)) begin
          key_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q == '0) begin
          base_d = red_next[W-1:0];
          acc_d  = '0;
          cnt_d  = IW'(W - 1);
`ifdef CLC_KEY_SKIP_LEAD_EN
          state_d = x_q[i_q] ? SQR : SCAN;
`else
          state_d = SQR;
`endif
        end else begin
          acc_d = red_next;
          cnt_d = cnt_q - IW'(1);
        end
      end
`ifdef CLC_KEY_SKIP_LEAD_EN
      SCAN: begin
        if (i_q == '0) begin
          key_d   = res_q;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          i_d     = i_dec;
          state_d = x_q[i_dec] ? SQR : SCAN;
        end
      end
`endif
      SQR: begin
        if (cnt_q == '0) begin
          res_d = mul_next[W-1:0];
          acc_d = '0;
          cnt_d = IW'(W - 1);
          if (x_q[i_q]) begin
            state_d = MUL;
          end else if (i_q == '0) begin
            key_d   = mul_next[W-1:0];
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            i_d = i_dec;
          end
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q - IW'(1);
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
          res_d = mul_next[W-1:0];
          acc_d = '0;
          cnt_d = IW'(W - 1);
          if (i_q == '0) begin
            key_d   = mul_next[W-1:0];
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            i_d     = i_dec;
            state_d = SQR;
          end
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q - IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      r2_q    <= '0;
      x_q     <= '0;
      p_q     <= '0;
      base_q  <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r2_q    <= r2_d;
      x_q     <= x_d;
      p_q     <= p_d;
      base_q  <= base_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
  end

  assign key  = key_q;
  assign err  = err_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
